dm_arbiter: RTL

Arbiter and access sequencer for the single-ported data memory added to the sisc datapath. Two requesters share the memory: the core load/store path, driven by ctrl, and a host/loader port used by the bench and for memory preload. The block grants the memory round-robin and sequences each access through issue, latency wait and response. It also produces a stall signal that ctrl uses to hold PC_WRITE low while a core access is outstanding.

---
 rtl/dm_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin arbiter and access sequencer for the shared data memory
module dm_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST_F,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // WAIT counts down from MEM_LAT-1 so the capture edge lands MEM_LAT cycles after ISSUE
    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_bad_mem_lat
            $error("dm_arbiter: MEM_LAT must be in 1..3");
        end
    endgenerate

    logic [1:0]        state;
    logic              owner;        // 0 = core, 1 = host
    logic              last_owner;
    logic [1:0]        lat_cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;

    logic any_req;
    logic pick_host;
    logic in_issue;
    logic in_resp;

    // On a tie the port that did not win last time goes first
    assign any_req   = core_req | host_req;
    assign pick_host = host_req & (~core_req | ~last_owner);

    // Sequencer: arbitration in IDLE, then issue, latency wait and response
    always_ff @(posedge CLK or posedge RST_F) begin
        if (RST_F) begin
            state        <= S_IDLE;
            owner        <= 1'b0;
            last_owner   <= 1'b1;
            lat_cnt      <= 2'd0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner     <= pick_host;
                        lat_we    <= pick_host ? host_we    : core_we;
                        lat_addr  <= pick_host ? host_addr  : core_addr;
                        lat_wdata <= pick_host ? host_wdata : core_wdata;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    last_owner <= owner;
                    if (lat_we) begin
                        state <= S_IDLE;
                    end else begin
                        lat_cnt <= LAT_INIT;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end else begin
                        if (owner) begin
                            host_rdata_q <= mem_rdata;
                        end else begin
                            core_rdata_q <= mem_rdata;
                        end
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_issue = (state == S_ISSUE);
    assign in_resp  = (state == S_RESP);

    // Memory bus is driven only in ISSUE so it reads as all-zero otherwise
    assign mem_en    = in_issue;
    assign mem_we    = in_issue & lat_we;
    assign mem_addr  = in_issue ? lat_addr  : '0;
    assign mem_wdata = in_issue ? lat_wdata : '0;

    assign core_gnt    = in_issue & ~owner;
    assign host_gnt    = in_issue & owner;
    assign core_rvalid = in_resp & ~owner;
    assign host_rvalid = in_resp & owner;
    assign core_rdata  = core_rdata_q;
    assign host_rdata  = host_rdata_q;

    // Stall releases in the store's issue cycle or in the load's response cycle
    assign core_stall = core_req & ~(core_gnt & lat_we) & ~core_rvalid;

endmodule
